branch_cmp_pipe: RTL

Parametrised, pipelined branch/compare unit, the successor to the single-width combinational equality comparator used in the decode stage. It evaluates eight MIPS-style compare conditions over WIDTH-bit operands in a two-stage, chunk-split pipeline, so wide operands still close timing. A valid/ready handshake with backpressure and a flush input let it sit between operand forwarding and the branch-resolve logic. A wrap-around counter records how many taken outcomes have been consumed.

---
 rtl/cmp_pkg.sv | 24 ++
 rtl/cmp_chunk.sv | 30 +++
 rtl/branch_cmp_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the pipelined branch/compare unit.
// Op encodings match the MIPS-style branch conditions used in decode.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LT  = 3'd2,
        OP_LTU = 3'd3,
        OP_LEZ = 3'd4,
        OP_GTZ = 3'd5,
        OP_LTZ = 3'd6,
        OP_GEZ = 3'd7
    } cmp_op_t;

    function automatic logic is_signed(input cmp_op_t op);
        return (op != OP_EQ) && (op != OP_NE) && (op != OP_LTU);
    endfunction

    function automatic logic is_zero_op(input cmp_op_t op);
        return (op == OP_LEZ) || (op == OP_GTZ) || (op == OP_LTZ) || (op == OP_GEZ);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational equality / unsigned less-than for one operand slice.
// flip_msb biases the slice MSBs so the unsigned compare acts as signed.
module cmp_chunk #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [CHUNK-1:0] b_raw,
    input  logic             flip_msb,
    output logic             eq,
    output logic             lt,
    output logic             eq_raw
);

    logic [CHUNK-1:0] a_x;
    logic [CHUNK-1:0] b_x;

    always_comb begin
        a_x = a;
        b_x = b;
        if (flip_msb) begin
            a_x[CHUNK-1] = ~a[CHUNK-1];
            b_x[CHUNK-1] = ~b[CHUNK-1];
        end
        eq     = (a == b);
        lt     = (a_x < b_x);
        eq_raw = (a == b_raw);
    end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Two-stage chunk-split branch/compare unit with valid/ready handshake,
// flush, and a wrap-around counter of consumed taken results.
module branch_cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 16,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_eq,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned NCH = WIDTH / CHUNK;

    cmp_op_t          op_in;
    logic [WIDTH-1:0] b_eff;
    logic [NCH-1:0]   ch_eq, ch_lt, ch_eq_raw;

    logic             s1_valid_q, s1_valid_d;
    cmp_op_t          s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [NCH-1:0]   s1_eq_q, s1_eq_d;
    logic [NCH-1:0]   s1_lt_q, s1_lt_d;
    logic [NCH-1:0]   s1_eq_raw_q, s1_eq_raw_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_taken_q, s2_taken_d;
    logic             s2_eq_q, s2_eq_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s1_adv, s2_adv;
    logic eq_all, lt_all, taken_c;

    assign op_in = cmp_op_t'(in_op);
    assign b_eff = is_zero_op(op_in) ? '0 : in_b;

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (in_a[g*CHUNK +: CHUNK]),
            .b        (b_eff[g*CHUNK +: CHUNK]),
            .b_raw    (in_b[g*CHUNK +: CHUNK]),
            .flip_msb ((g == NCH - 1) && is_signed(op_in)),
            .eq       (ch_eq[g]),
            .lt       (ch_lt[g]),
            .eq_raw   (ch_eq_raw[g])
        );
    end

    // Ripple LSB->MSB: a higher chunk decides unless it is equal.
    always_comb begin
        eq_all = &s1_eq_q;
        lt_all = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            lt_all = s1_lt_q[i] | (s1_eq_q[i] & lt_all);
        end
        case (s1_op_q)
            OP_EQ:   taken_c = eq_all;
            OP_NE:   taken_c = ~eq_all;
            OP_LEZ:  taken_c = lt_all | eq_all;
            OP_GTZ:  taken_c = ~(lt_all | eq_all);
            OP_GEZ:  taken_c = ~lt_all;
            default: taken_c = lt_all;
        endcase
    end

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & ~flush;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s1_eq_d     = s1_eq_q;
        s1_lt_d     = s1_lt_q;
        s1_eq_raw_d = s1_eq_raw_q;
        s2_valid_d  = s2_valid_q;
        s2_taken_d  = s2_taken_q;
        s2_eq_d     = s2_eq_q;
        s2_tag_d    = s2_tag_q;
        cnt_d       = cnt_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_op_d     = op_in;
            s1_tag_d    = in_tag;
            s1_eq_d     = ch_eq;
            s1_lt_d     = ch_lt;
            s1_eq_raw_d = ch_eq_raw;
        end

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            s2_taken_d = taken_c;
            s2_eq_d    = &s1_eq_raw_q;
            s2_tag_d   = s1_tag_q;
        end

        // A result handed over in the flush cycle is still consumed.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_taken_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_EQ;
            s1_tag_q    <= '0;
            s1_eq_q     <= '0;
            s1_lt_q     <= '0;
            s1_eq_raw_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_taken_q  <= 1'b0;
            s2_eq_q     <= 1'b0;
            s2_tag_q    <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_eq_q     <= s1_eq_d;
            s1_lt_q     <= s1_lt_d;
            s1_eq_raw_q <= s1_eq_raw_d;
            s2_valid_q  <= s2_valid_d;
            s2_taken_q  <= s2_taken_d;
            s2_eq_q     <= s2_eq_d;
            s2_tag_q    <= s2_tag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_taken = s2_taken_q;
    assign out_eq    = s2_eq_q;
    assign out_tag   = s2_tag_q;
    assign taken_cnt = cnt_q;

endmodule
